// File: rtl/tagged_rr_multiplexer.sv
// -----------------------------------------------------------------------------
// tagged_rr_multiplexer
//
// Purpose:
//   N-input to 1-output tagged stream multiplexer. Each input carries a tag;
//   beats whose tag equals ID are arbitrated round-robin onto a single output
//   stream, one beat per cycle. Beats with another tag are acknowledged
//   (in_ready=1) but ignored. A 2-entry skid buffer with registered outputs
//   keeps full throughput under backpressure.
//
//   LAST_HANDLING = 1 (FORWARD)  : out_last follows in_last of the granted beat.
//   LAST_HANDLING = 0 (WAIT_ALL) : last is collected from every input and a
//                                  single last is emitted, either on the beat
//                                  that completes the set or on a dummy beat
//                                  (data=0, keep=0, last=1).
//   FILTER_KEEP = 1              : matching beats with keep=0 are dropped.
//
// Optional feature:
//   `define TAGGED_RR_MUX_STATS_EN adds fwd_count / drop_count outputs.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (deassert synchronously)
//   in_data    in   NUM_INPUTS*DATA_WIDTH payloads, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_tag     in   NUM_INPUTS*TAG_WIDTH destination tags
//   in_keep    in   keep per input
//   in_last    in   end-of-stream per input
//   in_valid   in   valid per input
//   in_ready   out  ready per input
//   out_data   out  payload
//   out_keep   out  keep
//   out_last   out  end-of-stream
//   out_valid  out  valid
//   out_ready  in   downstream ready
//   fwd_count  out  (stats only) output handshakes, wraps at 2^32
//   drop_count out  (stats only) beats dropped by keep filtering, wraps at 2^32
// -----------------------------------------------------------------------------
module tagged_rr_multiplexer #(
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_INPUTS    = 4,
    parameter int TAG_WIDTH     = 4,
    parameter int ID            = 0,
    parameter int LAST_HANDLING = 1,
    parameter int FILTER_KEEP   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_tag,
    input  logic [NUM_INPUTS-1:0]            in_keep,
    input  logic [NUM_INPUTS-1:0]            in_last,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_keep,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef TAGGED_RR_MUX_STATS_EN
    ,
    output logic [31:0]                      fwd_count,
    output logic [31:0]                      drop_count
`endif
);

    localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [TAG_WIDTH-1:0] LP_ID = TAG_WIDTH'(ID);
    localparam logic LP_WAIT_ALL = (LAST_HANDLING == 0);
    localparam logic LP_FILTER   = (FILTER_KEEP != 0);

    // Skid buffer: head entry drives the outputs directly, tail holds overflow.
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_keep;
    logic                  r_out_last;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_tail_data;
    logic                  r_tail_keep;
    logic                  r_tail_last;
    logic                  r_tail_valid;

    logic [NUM_INPUTS-1:0] r_last_seen;
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [NUM_INPUTS-1:0] w_match;
    logic [NUM_INPUTS-1:0] w_elig;
    logic [NUM_INPUTS-1:0] w_drop;
    logic [NUM_INPUTS-1:0] w_grant_sel;
    logic [NUM_INPUTS-1:0] w_last_set;

    logic                  w_pop;
    logic                  w_can_push;
    logic                  w_grant_valid;
    logic [PTR_W-1:0]      w_grant_idx;
    int                    w_scan_idx;
    logic                  w_complete;
    logic                  w_dummy;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_push_keep;
    logic                  w_push_last;

    assign w_pop      = r_out_valid & out_ready;
    // Space exists unless both entries are occupied and nothing leaves.
    assign w_can_push = ~(r_out_valid & r_tail_valid) | w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
            assign w_match[gi] = (in_tag[gi*TAG_WIDTH +: TAG_WIDTH] == LP_ID);
            assign w_elig[gi]  = in_valid[gi] & w_match[gi] & ~r_last_seen[gi]
                               & (~LP_FILTER | in_keep[gi]);
            // Drops are held off while the skid is full so that a dropped
            // last can still trigger a dummy push in the same cycle.
            assign w_drop[gi]  = LP_FILTER & in_valid[gi] & w_match[gi] & ~r_last_seen[gi]
                               & ~in_keep[gi] & w_can_push;
            assign w_grant_sel[gi] = w_grant_valid & (w_grant_idx == PTR_W'(gi));
            assign in_ready[gi] = ~w_match[gi] | w_grant_sel[gi] | w_drop[gi];
            // Last arrives either on a non-matching stream (seen immediately)
            // or on a matching beat that is actually consumed.
            assign w_last_set[gi] = LP_WAIT_ALL & in_valid[gi] & in_last[gi]
                                  & (~w_match[gi] | w_grant_sel[gi] | w_drop[gi]);
        end
    endgenerate

    // Round-robin: first eligible index at or after r_rr_ptr, wrapping.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = 0;
        if (w_can_push) begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                w_scan_idx = int'(r_rr_ptr) + k;
                if (w_scan_idx >= NUM_INPUTS) begin
                    w_scan_idx = w_scan_idx - NUM_INPUTS;
                end
                if (!w_grant_valid && w_elig[PTR_W'(w_scan_idx)]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = PTR_W'(w_scan_idx);
                end
            end
        end
    end

    // Completion needs skid space for the (possibly dummy) last beat;
    // otherwise it is deferred and the seen bits keep accumulating.
    assign w_complete  = LP_WAIT_ALL & (&(r_last_seen | w_last_set)) & w_can_push;
    assign w_dummy     = w_complete & ~w_grant_valid;
    assign w_push      = w_grant_valid | w_dummy;
    assign w_push_data = w_grant_valid ? in_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH]
                                       : '0;
    assign w_push_keep = w_grant_valid & in_keep[w_grant_idx];
    assign w_push_last = LP_WAIT_ALL ? w_complete : (w_grant_valid & in_last[w_grant_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_keep   <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_tail_data  <= '0;
            r_tail_keep  <= 1'b0;
            r_tail_last  <= 1'b0;
            r_tail_valid <= 1'b0;
            r_last_seen  <= '0;
            r_rr_ptr     <= '0;
        end else begin
            // Skid buffer update: head refills from tail first (FIFO order).
            if (!r_out_valid || w_pop) begin
                if (r_tail_valid) begin
                    r_out_data   <= r_tail_data;
                    r_out_keep   <= r_tail_keep;
                    r_out_last   <= r_tail_last;
                    r_out_valid  <= 1'b1;
                    r_tail_valid <= w_push;
                    if (w_push) begin
                        r_tail_data <= w_push_data;
                        r_tail_keep <= w_push_keep;
                        r_tail_last <= w_push_last;
                    end
                end else begin
                    r_out_valid <= w_push;
                    if (w_push) begin
                        r_out_data <= w_push_data;
                        r_out_keep <= w_push_keep;
                        r_out_last <= w_push_last;
                    end
                end
            end else if (w_push) begin
                r_tail_data  <= w_push_data;
                r_tail_keep  <= w_push_keep;
                r_tail_last  <= w_push_last;
                r_tail_valid <= 1'b1;
            end

            if (w_complete) begin
                r_last_seen <= '0;
            end else if (LP_WAIT_ALL) begin
                r_last_seen <= r_last_seen | w_last_set;
            end

            if (w_grant_valid) begin
                if (w_grant_idx == PTR_W'(NUM_INPUTS - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_grant_idx + 1'b1;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

`ifdef TAGGED_RR_MUX_STATS_EN
    logic [31:0] r_fwd_count;
    logic [31:0] r_drop_count;
    logic [31:0] w_drop_num;

    always_comb begin
        w_drop_num = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_drop_num = w_drop_num + 32'(w_drop[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_fwd_count  <= r_fwd_count + 32'(w_pop);
            r_drop_count <= r_drop_count + w_drop_num;
        end
    end

    assign fwd_count  = r_fwd_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_tagged_rr_multiplexer.sv
// -----------------------------------------------------------------------------
// Testbench for tagged_rr_multiplexer. Two instances share the input buses:
// u_fwd (ID=2, FORWARD last handling) and u_wait (ID=2, WAIT_ALL).
// -----------------------------------------------------------------------------
module tb_tagged_rr_multiplexer;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N*DW-1:0]   in_data;
    logic [N*TW-1:0]   in_tag;
    logic [N-1:0]      in_keep;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_valid;
    logic              out_ready;

    logic [N-1:0]      f_in_ready;
    logic [DW-1:0]     f_out_data;
    logic              f_out_keep, f_out_last, f_out_valid;
    logic [N-1:0]      w_in_ready;
    logic [DW-1:0]     w_out_data;
    logic              w_out_keep, w_out_last, w_out_valid;
`ifdef TAGGED_RR_MUX_STATS_EN
    logic [31:0]       f_fwd_count, f_drop_count, w_fwd_count, w_drop_count;
`endif

    tagged_rr_multiplexer #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TAG_WIDTH(TW), .ID(2),
                            .LAST_HANDLING(1), .FILTER_KEEP(1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_tag(in_tag), .in_keep(in_keep),
        .in_last(in_last), .in_valid(in_valid), .in_ready(f_in_ready),
        .out_data(f_out_data), .out_keep(f_out_keep), .out_last(f_out_last),
        .out_valid(f_out_valid), .out_ready(out_ready)
`ifdef TAGGED_RR_MUX_STATS_EN
        , .fwd_count(f_fwd_count), .drop_count(f_drop_count)
`endif
    );

    tagged_rr_multiplexer #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TAG_WIDTH(TW), .ID(2),
                            .LAST_HANDLING(0), .FILTER_KEEP(1)) u_wait (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_tag(in_tag), .in_keep(in_keep),
        .in_last(in_last), .in_valid(in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_keep(w_out_keep), .out_last(w_out_last),
        .out_valid(w_out_valid), .out_ready(out_ready)
`ifdef TAGGED_RR_MUX_STATS_EN
        , .fwd_count(w_fwd_count), .drop_count(w_drop_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] dat_a [N];
    logic [TW-1:0] tag_a [N];
    logic [7:0]    seq   [N];
    logic [N-1:0]  val_v, keep_v, last_v;
    logic [N-1:0]  rdy_f, rdy_w;

    function automatic logic [DW-1:0] exp_data(int src, int s);
        return {48'd0, 8'(src), 8'(s)};
    endfunction

    task automatic apply();
        in_valid = val_v;
        in_keep  = keep_v;
        in_last  = last_v;
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = dat_a[i];
            in_tag[i*TW +: TW]  = tag_a[i];
        end
    endtask

    // Drive current inputs, sample ready before the edge, return on the next negedge.
    task automatic step();
        apply();
        #1;
        rdy_f = f_in_ready;
        rdy_w = w_in_ready;
        @(negedge clk);
    endtask

    task automatic set_in(int i, logic v, logic [TW-1:0] t, logic k, logic l, logic [DW-1:0] d);
        val_v[i]  = v;
        tag_a[i]  = t;
        keep_v[i] = k;
        last_v[i] = l;
        dat_a[i]  = d;
    endtask

    // Streaming sources for u_fwd: payload encodes source index and sequence.
    task automatic load_stream();
        for (int i = 0; i < N; i++) dat_a[i] = exp_data(i, int'(seq[i]));
    endtask

    task automatic advance_stream();
        for (int i = 0; i < N; i++) if (val_v[i] && rdy_f[i]) seq[i] = seq[i] + 8'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            dat_a[i] = '0;
            tag_a[i] = '0;
            seq[i]   = '0;
        end
        val_v = '0; keep_v = '0; last_v = '0;
        out_ready = 1'b1;
        apply();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (f_out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got f=%b w=%b exp 0", f_out_valid, w_out_valid);
        end
        checks++;
        if (f_out_data !== '0 || f_out_keep !== 1'b0 || f_out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got data=%h keep=%b last=%b exp 0", f_out_data, f_out_keep, f_out_last);
        end
        checks++;
        if (f_in_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_nonmatch_ready got %b exp 1111", f_in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'd2, 1'b1, 1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            load_stream();
            step();
            advance_stream();
            $display("fair beat %0d valid=%b data=%h", k, f_out_valid, f_out_data);
            checks++;
            if (f_out_valid !== 1'b1 || f_out_data !== exp_data(k % 4, k / 4)) begin
                failures++;
                $display("FAIL fair_beat[%0d] got valid=%b data=%h exp valid=1 data=%h",
                         k, f_out_valid, f_out_data, exp_data(k % 4, k / 4));
            end
        end
    endtask

    task automatic test_tag_filter();
        do_reset();
        set_in(0, 1'b1, 4'd2, 1'b1, 1'b0, '0);
        set_in(1, 1'b1, 4'd3, 1'b1, 1'b0, '0);
        set_in(2, 1'b1, 4'd2, 1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            load_stream();
            step();
            advance_stream();
            $display("tag beat %0d valid=%b data=%h", k, f_out_valid, f_out_data);
            checks++;
            if (rdy_f[1] !== 1'b1) begin
                failures++;
                $display("FAIL tag_ready1[%0d] got %b exp 1", k, rdy_f[1]);
            end
            checks++;
            if (f_out_valid !== 1'b1 || f_out_data !== exp_data((k % 2 == 0) ? 0 : 2, k / 2)) begin
                failures++;
                $display("FAIL tag_beat[%0d] got valid=%b data=%h exp %h", k, f_out_valid,
                         f_out_data, exp_data((k % 2 == 0) ? 0 : 2, k / 2));
            end
        end
    endtask

    task automatic test_backpressure();
        int  k_exp;
        logic pop;
        do_reset();
        k_exp = 0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'd2, 1'b1, 1'b0, '0);
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 5);
            pop = f_out_valid & out_ready;
            load_stream();
            step();
            advance_stream();
            if (pop) k_exp++;
            if (c >= 2 && c <= 4) begin
                checks++;
                if (rdy_f !== 4'b0000) begin
                    failures++;
                    $display("FAIL bp_ready[%0d] got %b exp 0000", c, rdy_f);
                end
            end
            $display("bp cycle %0d valid=%b data=%h", c, f_out_valid, f_out_data);
            checks++;
            if (f_out_valid !== 1'b1 || f_out_data !== exp_data(k_exp % 4, k_exp / 4)) begin
                failures++;
                $display("FAIL bp_beat[%0d] got valid=%b data=%h exp %h", c, f_out_valid,
                         f_out_data, exp_data(k_exp % 4, k_exp / 4));
            end
        end
        // Drain what is still buffered with the sources idle.
        val_v = '0;
        out_ready = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (f_out_valid) k_exp++;
            step();
            if (f_out_valid) begin
                checks++;
                if (f_out_data !== exp_data(k_exp % 4, k_exp / 4)) begin
                    failures++;
                    $display("FAIL bp_drain[%0d] got %h exp %h", d, f_out_data,
                             exp_data(k_exp % 4, k_exp / 4));
                end
            end
        end
        checks++;
        if (k_exp !== 9) begin
            failures++;
            $display("FAIL bp_total got %0d beats exp 9", k_exp);
        end
    endtask

    task automatic test_filter_keep();
        do_reset();
        set_in(0, 1'b1, 4'd2, 1'b0, 1'b0, 64'hAA);
        step();
        checks++;
        if (rdy_f[0] !== 1'b1 || f_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL keep_drop got ready=%b valid=%b exp ready=1 valid=0", rdy_f[0], f_out_valid);
        end
        set_in(0, 1'b1, 4'd2, 1'b1, 1'b0, 64'hBB);
        step();
        checks++;
        if (f_out_valid !== 1'b1 || f_out_data !== 64'hBB || f_out_keep !== 1'b1) begin
            failures++;
            $display("FAIL keep_pass got valid=%b data=%h keep=%b exp 1/bb/1", f_out_valid, f_out_data, f_out_keep);
        end
        val_v = '0;
        step();
        checks++;
        if (f_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL keep_empty got valid=%b exp 0", f_out_valid);
        end
`ifdef TAGGED_RR_MUX_STATS_EN
        checks++;
        if (f_drop_count !== 32'd1 || f_fwd_count !== 32'd1) begin
            failures++;
            $display("FAIL keep_stats got drop=%0d fwd=%0d exp 1/1", f_drop_count, f_fwd_count);
        end
`endif
    endtask

    task automatic test_wait_all();
        logic [DW-1:0] exp_d [5];
        logic          exp_l [5];
        exp_d[0] = 64'h30; exp_d[1] = 64'h31; exp_d[2] = 64'h32; exp_d[3] = 64'h33; exp_d[4] = 64'h40;
        exp_l[0] = 1'b0;   exp_l[1] = 1'b0;   exp_l[2] = 1'b0;   exp_l[3] = 1'b1;   exp_l[4] = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: set_in(0, 1'b1, 4'd2, 1'b1, 1'b1, 64'h30);
                1: begin set_in(0, 1'b1, 4'd2, 1'b1, 1'b0, 64'h40); set_in(1, 1'b1, 4'd2, 1'b1, 1'b1, 64'h31); end
                2: begin set_in(1, 1'b0, 4'd2, 1'b0, 1'b0, '0);     set_in(2, 1'b1, 4'd2, 1'b1, 1'b1, 64'h32); end
                3: begin set_in(2, 1'b0, 4'd2, 1'b0, 1'b0, '0);     set_in(3, 1'b1, 4'd2, 1'b1, 1'b1, 64'h33); end
                default: set_in(3, 1'b0, 4'd2, 1'b0, 1'b0, '0);
            endcase
            step();
            $display("wait beat %0d valid=%b data=%h last=%b", c, w_out_valid, w_out_data, w_out_last);
            if (c == 1 || c == 4) begin
                checks++;
                if (rdy_w[0] !== (c == 4)) begin
                    failures++;
                    $display("FAIL wait_ready0[%0d] got %b exp %b", c, rdy_w[0], (c == 4));
                end
            end
            checks++;
            if (w_out_valid !== 1'b1 || w_out_data !== exp_d[c] || w_out_last !== exp_l[c]) begin
                failures++;
                $display("FAIL wait_beat[%0d] got valid=%b data=%h last=%b exp 1/%h/%b", c,
                         w_out_valid, w_out_data, w_out_last, exp_d[c], exp_l[c]);
            end
        end
        val_v = '0;
        step();
        checks++;
        if (w_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle got valid=%b exp 0", w_out_valid);
        end
    endtask

    task automatic test_wait_dummy();
        do_reset();
        set_in(0, 1'b1, 4'd2, 1'b1, 1'b1, 64'h50);
        step();
        set_in(0, 1'b0, 4'd2, 1'b0, 1'b0, '0);
        set_in(1, 1'b1, 4'd2, 1'b1, 1'b1, 64'h51);
        step();
        set_in(1, 1'b0, 4'd2, 1'b0, 1'b0, '0);
        set_in(2, 1'b1, 4'd2, 1'b1, 1'b1, 64'h52);
        step();
        checks++;
        if (w_out_valid !== 1'b1 || w_out_data !== 64'h52 || w_out_last !== 1'b0) begin
            failures++;
            $display("FAIL dummy_pre got valid=%b data=%h last=%b exp 1/52/0", w_out_valid, w_out_data, w_out_last);
        end
        set_in(2, 1'b0, 4'd2, 1'b0, 1'b0, '0);
        set_in(3, 1'b1, 4'd5, 1'b1, 1'b1, 64'h53);
        step();
        $display("dummy beat valid=%b data=%h keep=%b last=%b", w_out_valid, w_out_data, w_out_keep, w_out_last);
        checks++;
        if (rdy_w[3] !== 1'b1) begin
            failures++;
            $display("FAIL dummy_nonmatch_ready got %b exp 1", rdy_w[3]);
        end
        checks++;
        if (w_out_valid !== 1'b1 || w_out_data !== '0 || w_out_keep !== 1'b0 || w_out_last !== 1'b1) begin
            failures++;
            $display("FAIL dummy_beat got valid=%b data=%h keep=%b last=%b exp 1/0/0/1",
                     w_out_valid, w_out_data, w_out_keep, w_out_last);
        end
        val_v = '0;
        step();
        checks++;
        if (w_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dummy_idle got valid=%b exp 0", w_out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'd2, 1'b1, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            load_stream();
            step();
            advance_stream();
        end
        checks++;
        if (f_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_prefill got valid=%b exp 1", f_out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (f_out_valid !== 1'b0 || f_out_data !== '0) begin
            failures++;
            $display("FAIL areset_immediate got valid=%b data=%h exp 0/0", f_out_valid, f_out_data);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) seq[i] = '0;
        val_v = 4'b1010;
        out_ready = 1'b1;
        rst_n = 1'b1;
        load_stream();
        step();
        checks++;
        if (f_out_valid !== 1'b1 || f_out_data !== exp_data(1, 0)) begin
            failures++;
            $display("FAIL areset_first_grant got valid=%b data=%h exp 1/%h", f_out_valid, f_out_data, exp_data(1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_tag_filter();
        test_backpressure();
        test_filter_keep();
        test_wait_all();
        test_wait_dummy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
